// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream packet arbiter.
package axis_pkg;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} arb_state_t;
  localparam int PKT_CNT_W = 16;
endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Source-side and sink-side stream bundle plus arbiter status.
interface axis_packet_arbiter_if
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4
);
  localparam int IDW = $clog2(NUM_SRC);

  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]            s_tvalid;
  logic [NUM_SRC-1:0]            s_tready;
  logic [NUM_SRC-1:0]            s_tlast;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tvalid;
  logic                          m_tready;
  logic                          m_tlast;
  logic [IDW-1:0]                grant_id;
  logic                          busy;
  logic [PKT_CNT_W-1:0]          pkt_count;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, grant_id, busy, pkt_count
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, grant_id, busy, pkt_count
  );
endinterface

// File: rtl/axis_rr_select.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping.
module axis_rr_select #(
  parameter  int NUM_SRC = 4,
  localparam int IDW     = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);
  int j;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_SRC;
      if (req[j]) begin
        any = 1'b1;
        idx = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin mux of NUM_SRC streams into one registered output.
module axis_packet_arbiter
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  axis_packet_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_SRC);

  arb_state_t            state_q;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d, grant_q, sel_idx;
  logic                  sel_any;
  logic [DATA_WIDTH-1:0] m_tdata_q, g_data;
  logic                  m_tvalid_q, m_tlast_q;
  logic [PKT_CNT_W-1:0]  pkt_cnt_q;
  logic [NUM_SRC-1:0]    s_tready;
  logic                  out_free, accept, g_last;

  axis_rr_select #(.NUM_SRC(NUM_SRC)) u_sel (
    .req (bus.s_tvalid),
    .ptr (rr_ptr_q),
    .any (sel_any),
    .idx (sel_idx)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = !m_tvalid_q || bus.m_tready;
  assign g_data   = bus.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign g_last   = bus.s_tlast[grant_q];
  assign accept   = (state_q == STREAM) && bus.s_tvalid[grant_q] && out_free;
  assign rr_ptr_d = (grant_q == IDW'(NUM_SRC - 1)) ? '0 : grant_q + IDW'(1);

  always_comb begin
    s_tready = '0;
    if (state_q == STREAM) s_tready[grant_q] = out_free;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      if (m_tvalid_q && bus.m_tready && m_tlast_q) pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);

      if (accept) begin
        m_tdata_q  <= g_data;
        m_tlast_q  <= g_last;
        m_tvalid_q <= 1'b1;
      end else if (bus.m_tready) begin
        m_tvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: if (sel_any) begin
          grant_q <= sel_idx;
          state_q <= STREAM;
        end
        STREAM: if (accept && g_last) begin
          state_q  <= IDLE;
          rr_ptr_q <= rr_ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_tready  = s_tready;
  assign bus.m_tdata   = m_tdata_q;
  assign bus.m_tvalid  = m_tvalid_q;
  assign bus.m_tlast   = m_tlast_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == STREAM);
  assign bus.pkt_count = pkt_cnt_q;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed stimulus with an in-order scoreboard of expected output beats.
module tb_axis_packet_arbiter;
  localparam int DW = 8;
  localparam int NS = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  int   cyc_cnt = 0;
  beat_t exp_q[$];
  int    obs_cyc[$];

  axis_packet_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

  axis_packet_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(input logic [DW-1:0] base, input int n);
    for (int b = 0; b < n; b++) push(base + DW'(b), b == n - 1);
  endtask

  // Holds the current beat until an edge where ready was seen high.
  task automatic wait_acc(input int src, inout int cyc);
    int   w = 0;
    logic rdy;
    do begin
      @(negedge clk);
      rdy = bus.s_tready[src];
      @(posedge clk);
      cyc++;
      w++;
    end while (!rdy && w < 100);
    if (!rdy) chk("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic send_pkt(input int src, input int n, input logic [DW-1:0] base, output int cyc);
    cyc = 0;
    for (int b = 0; b < n; b++) begin
      bus.s_tdata[src*DW +: DW] = base + DW'(b);
      bus.s_tlast[src]  = (b == n - 1);
      bus.s_tvalid[src] = 1'b1;
      wait_acc(src, cyc);
    end
    bus.s_tvalid[src] = 1'b0;
    bus.s_tlast[src]  = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stall stability.
  initial begin
    logic          stall = 1'b0;
    logic [DW-1:0] hd = '0;
    logic          hl = 1'b0;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (stall && bus.m_tvalid) begin
        chk("hold_data", bus.m_tdata, hd);
        chk("hold_last", bus.m_tlast, hl);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", bus.m_tdata, e.d);
          chk("beat_last", bus.m_tlast, e.l);
        end
        obs_cyc.push_back(cyc_cnt);
      end
      stall = bus.m_tvalid && !bus.m_tready;
      hd = bus.m_tdata;
      hl = bus.m_tlast;
    end
  end

  initial begin
    int c, c2, s;
    reset_n = 1'b0;
    bus.s_tdata = '0;
    bus.s_tvalid = '0;
    bus.s_tlast = '0;
    bus.m_tready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      chk("rst_m_tvalid", bus.m_tvalid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_s_tready", bus.s_tready, 0);
    end
    chk("rst_m_tdata", bus.m_tdata, 0);
    chk("rst_m_tlast", bus.m_tlast, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_pkt_count", bus.pkt_count, 0);
    tick();

    // Single 16-beat packet from source 0
    s = obs_cyc.size();
    push_pkt(8'h00, 16);
    send_pkt(0, 16, 8'h00, c);
    chk("t2_src_cycles", c, 17);
    repeat (3) tick();
    chk("t2_out_span", obs_cyc[s+15] - obs_cyc[s], 15);
    chk("t2_pkt_count", bus.pkt_count, 1);
    chk("t2_grant", bus.grant_id, 0);
    chk("t2_busy", bus.busy, 0);

    // All sources valid, 2-beat packets, starting from a fresh pointer
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    s = obs_cyc.size();
    push_pkt(8'h00, 2);
    push_pkt(8'h10, 2);
    push_pkt(8'h20, 2);
    push_pkt(8'h30, 2);
    push_pkt(8'h02, 2);
    fork
      begin send_pkt(0, 2, 8'h00, c); send_pkt(0, 2, 8'h02, c); end
      send_pkt(1, 2, 8'h10, c2);
      begin int c3; send_pkt(2, 2, 8'h20, c3); end
      begin int c4; send_pkt(3, 2, 8'h30, c4); end
    join
    repeat (3) tick();
    chk("t3_out_span", obs_cyc[s+9] - obs_cyc[s], 13);
    chk("t3_pair_gap", obs_cyc[s+2] - obs_cyc[s+1], 2);
    chk("t3_pkt_count", bus.pkt_count, 5);

    // Source 2 with a two-cycle downstream stall
    push_pkt(8'h40, 6);
    fork
      send_pkt(2, 6, 8'h40, c);
      begin
        repeat (3) tick();
        bus.m_tready = 1'b1;
        tick();
        bus.m_tready = 1'b0;
        tick();
        bus.m_tready = 1'b0;
        tick();
        bus.m_tready = 1'b1;
      end
      repeat (12) begin
        @(negedge clk);
        if (bus.busy) begin
          chk("t4_s2_ready", bus.s_tready[2], !bus.m_tvalid || bus.m_tready);
          chk("t4_other_ready", bus.s_tready & 4'b1011, 0);
        end
      end
    join
    chk("t4_src_cycles", c, 9);
    repeat (2) tick();
    chk("t4_grant", bus.grant_id, 2);

    // Pointer lands on 2 after a source-1 packet; source 3 then beats source 1
    push_pkt(8'h50, 2);
    send_pkt(1, 2, 8'h50, c);
    push_pkt(8'h70, 2);
    push_pkt(8'h58, 2);
    fork
      send_pkt(3, 2, 8'h70, c);
      send_pkt(1, 2, 8'h58, c2);
    join
    chk("t5_grant", bus.grant_id, 1);
    push_pkt(8'h5C, 1);
    send_pkt(1, 1, 8'h5C, c);
    chk("t5_single_cycles", c, 2);
    repeat (3) tick();

    // Reset in the middle of a packet
    c = 0;
    for (int b = 0; b < 5; b++) begin
      push(8'h80 + DW'(b), 1'b0);
      bus.s_tdata[0*DW +: DW] = 8'h80 + DW'(b);
      bus.s_tlast[0]  = 1'b0;
      bus.s_tvalid[0] = 1'b1;
      wait_acc(0, c);
    end
    bus.s_tdata[0*DW +: DW] = 8'h85;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.s_tvalid[0] = 1'b0;
    @(negedge clk);
    chk("t6_m_tvalid", bus.m_tvalid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_pkt_count", bus.pkt_count, 0);
    tick();
    push_pkt(8'h90, 1);
    push_pkt(8'hA0, 1);
    fork
      send_pkt(0, 1, 8'h90, c);
      send_pkt(2, 1, 8'hA0, c2);
    join
    repeat (3) tick();
    chk("t6_pkt_count_after", bus.pkt_count, 2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
